// File: rtl/bsg_gateway_watchdog_pkg.sv
// Shared types and helpers for the gateway progress watchdog.
// Holds the per-channel state encoding and a width helper that is safe for n <= 1.
package bsg_gateway_watchdog_pkg;

    typedef enum logic [1:0] {
        e_wd_idle    = 2'd0,
        e_wd_wait    = 2'd1,
        e_wd_timeout = 2'd2
    } wd_state_e;

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_gateway_watchdog_channel.sv
// One monitored valid/ready channel: stall FSM with saturating stall counter.
// enter_o pulses on the cycle the channel commits to the absorbing timeout state.
module bsg_gateway_watchdog_channel
    import bsg_gateway_watchdog_pkg::*;
#(
    parameter int stall_limit_p = 1024
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    input  logic clear_i,
    input  logic v_i,
    input  logic ready_and_i,
    output logic enter_o,
    output logic timeout_o
);

    localparam int cnt_w = safe_clog2(stall_limit_p + 1);

    wd_state_e state_q, state_d;
    logic [cnt_w-1:0] cnt_q, cnt_d;
    logic stall, at_limit;

    assign stall    = v_i & ~ready_and_i;
    assign at_limit = (cnt_q == cnt_w'(stall_limit_p - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        enter_o = 1'b0;
        if (clear_i) begin
            state_d = e_wd_idle;
            cnt_d   = '0;
        end else if (en_i) begin
            unique case (state_q)
                e_wd_idle: begin
                    if (stall) begin
                        state_d = e_wd_wait;
                        cnt_d   = cnt_w'(1);
                    end
                end
                e_wd_wait: begin
                    if (!stall) begin
                        state_d = e_wd_idle;
                        cnt_d   = '0;
                    end else if (at_limit) begin
                        // counter parks at the limit; timeout never leaves
                        state_d = e_wd_timeout;
                        cnt_d   = cnt_w'(stall_limit_p);
                        enter_o = 1'b1;
                    end else begin
                        cnt_d = cnt_q + cnt_w'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= e_wd_idle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign timeout_o = (state_q == e_wd_timeout);

endmodule

// File: rtl/bsg_gateway_progress_watchdog.sv
// Progress watchdog: per-channel stall timeouts, first-timeout latch, global deadlock.
// Define BSG_GATEWAY_WATCHDOG_FINISH_EN to report and $finish on the first trip.
module bsg_gateway_progress_watchdog
    import bsg_gateway_watchdog_pkg::*;
#(
    parameter int num_channels_p = 4,
    parameter int stall_limit_p  = 1024,
    parameter int idle_limit_p   = 500000
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   en_i,
    input  logic                                   clear_i,
    input  logic [num_channels_p-1:0]              v_i,
    input  logic [num_channels_p-1:0]              ready_and_i,
    output logic [num_channels_p-1:0]              timeout_o,
    output logic [safe_clog2(num_channels_p)-1:0]  first_id_o,
    output logic                                   first_v_o,
    output logic                                   deadlock_o
);

    localparam int id_w   = safe_clog2(num_channels_p);
    localparam int idle_w = safe_clog2(idle_limit_p + 1);

    logic [num_channels_p-1:0] enter, hs;
    logic [idle_w-1:0]         idle_q, idle_d;
    logic [id_w-1:0]           first_id_q, first_id_d;
    logic                      first_v_q, first_v_d;
    logic                      dead_q, dead_d;

    for (genvar c = 0; c < num_channels_p; c++) begin : g_ch
        bsg_gateway_watchdog_channel #(
            .stall_limit_p(stall_limit_p)
        ) u_ch (
            .clk_i      (clk_i),
            .reset_i    (reset_i),
            .en_i       (en_i),
            .clear_i    (clear_i),
            .v_i        (v_i[c]),
            .ready_and_i(ready_and_i[c]),
            .enter_o    (enter[c]),
            .timeout_o  (timeout_o[c])
        );
    end

    assign hs = v_i & ready_and_i;

    always_comb begin
        idle_d     = idle_q;
        dead_d     = dead_q;
        first_id_d = first_id_q;
        first_v_d  = first_v_q;
        if (clear_i) begin
            idle_d     = '0;
            dead_d     = 1'b0;
            first_id_d = '0;
            first_v_d  = 1'b0;
        end else if (en_i) begin
            if (|hs) begin
                idle_d = '0;
            end else if (|v_i) begin
                if (idle_q != idle_w'(idle_limit_p))
                    idle_d = idle_q + idle_w'(1);
                if (idle_q >= idle_w'(idle_limit_p - 1))
                    dead_d = 1'b1;
            end
            // scan downward so the lowest simultaneous entry wins
            if (!first_v_q && (|enter)) begin
                first_v_d = 1'b1;
                for (int c = num_channels_p - 1; c >= 0; c--)
                    if (enter[c]) first_id_d = id_w'(c);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            idle_q     <= '0;
            dead_q     <= 1'b0;
            first_id_q <= '0;
            first_v_q  <= 1'b0;
        end else begin
            idle_q     <= idle_d;
            dead_q     <= dead_d;
            first_id_q <= first_id_d;
            first_v_q  <= first_v_d;
        end
    end

    assign first_id_o = first_id_q;
    assign first_v_o  = first_v_q;
    assign deadlock_o = dead_q;

`ifdef BSG_GATEWAY_WATCHDOG_FINISH_EN
    logic [63:0] cyc_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) cyc_q <= '0;
        else         cyc_q <= cyc_q + 64'd1;
    end

    always @(negedge clk_i) begin
        if (!reset_i && (first_v_q || dead_q)) begin
            if (first_v_q)
                $display("watchdog: channel %0d timeout, cycle %0d",
                         first_id_q, cyc_q);
            else
                $display("watchdog: DEADLOCK, cycle %0d", cyc_q);
            $finish;
        end
    end
`else
    // synthesizable build: no simulation control
`endif

endmodule

// File: tb/tb_bsg_gateway_progress_watchdog.sv
// Scoreboard bench: two watchdogs (stall limit 8 and 64, idle limit 16) on shared stimulus.
// A run-length reference model predicts outputs; a monitor compares at each negedge.
module tb_bsg_gateway_progress_watchdog;

    localparam int N  = 4;
    localparam int IL = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic clr = 1'b0;
    logic [3:0] v = '0;
    logic [3:0] r = '0;

    logic [3:0] to_a, to_b;
    logic [1:0] id_a, id_b;
    logic fv_a, fv_b, dl_a, dl_b;

    always #5 clk = ~clk;

    bsg_gateway_progress_watchdog #(
        .num_channels_p(N), .stall_limit_p(8), .idle_limit_p(IL)
    ) u_dut_a (
        .clk_i(clk), .reset_i(rst), .en_i(en), .clear_i(clr),
        .v_i(v), .ready_and_i(r), .timeout_o(to_a),
        .first_id_o(id_a), .first_v_o(fv_a), .deadlock_o(dl_a)
    );

    bsg_gateway_progress_watchdog #(
        .num_channels_p(N), .stall_limit_p(64), .idle_limit_p(IL)
    ) u_dut_b (
        .clk_i(clk), .reset_i(rst), .en_i(en), .clear_i(clr),
        .v_i(v), .ready_and_i(r), .timeout_o(to_b),
        .first_id_o(id_b), .first_v_o(fv_b), .deadlock_o(dl_b)
    );

    typedef struct packed {
        logic [3:0] to;
        logic       fv;
        logic [1:0] id;
        logic       dl;
    } exp_t;

    typedef struct packed {
        exp_t a;
        exp_t b;
    } pair_t;

    pair_t q[$];
    pair_t cur;
    event kick;
    int vectors = 0;
    int errors  = 0;

    // reference model: consecutive-stall run lengths and sticky flags
    int lim[2] = '{8, 64};
    int run[2][4];
    bit tof[2][4];
    bit m_fv[2];
    int m_id[2];
    int idle_run[2];
    bit m_dl[2];

    function automatic void model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < N; c++) begin
                run[d][c] = 0;
                tof[d][c] = 1'b0;
            end
            m_fv[d] = 1'b0;
            m_id[d] = 0;
            idle_run[d] = 0;
            m_dl[d] = 1'b0;
        end
    endfunction

    function automatic void model_step(bit e, bit cl, logic [3:0] vv, logic [3:0] rr);
        if (cl) begin
            model_clear();
            return;
        end
        if (!e) return;
        for (int d = 0; d < 2; d++) begin
            int first = -1;
            for (int c = 0; c < N; c++) begin
                if (!tof[d][c]) begin
                    if (vv[c] && !rr[c]) begin
                        run[d][c]++;
                        if (run[d][c] == lim[d]) begin
                            tof[d][c] = 1'b1;
                            if (first < 0) first = c;
                        end
                    end else begin
                        run[d][c] = 0;
                    end
                end
            end
            if (!m_fv[d] && first >= 0) begin
                m_fv[d] = 1'b1;
                m_id[d] = first;
            end
            if ((vv & rr) != 4'b0) begin
                idle_run[d] = 0;
            end else if (vv != 4'b0) begin
                if (idle_run[d] < IL) idle_run[d]++;
                if (idle_run[d] >= IL) m_dl[d] = 1'b1;
            end
        end
    endfunction

    function automatic exp_t pred(int d);
        exp_t x;
        for (int c = 0; c < N; c++) x.to[c] = tof[d][c];
        x.fv = m_fv[d];
        x.id = 2'(m_id[d]);
        x.dl = m_dl[d];
        return x;
    endfunction

    function automatic pair_t predict();
        pair_t p;
        p.a = pred(0);
        p.b = pred(1);
        return p;
    endfunction

    task automatic chk(string nm, exp_t want, exp_t got);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got to=%b fv=%b id=%0d dl=%b, want to=%b fv=%b id=%0d dl=%b",
                     nm, got.to, got.fv, got.id, got.dl,
                     want.to, want.fv, want.id, want.dl);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk or kick);
            if (q.size() > 0) begin
                cur = q.pop_front();
                chk("dut_a", cur.a, {to_a, fv_a, id_a, dl_a});
                chk("dut_b", cur.b, {to_b, fv_b, id_b, dl_b});
            end
        end
    end

    task automatic step(bit e, bit cl, logic [3:0] vv, logic [3:0] rr);
        en  = e;
        clr = cl;
        v   = vv;
        r   = rr;
        model_step(e, cl, vv, rr);
        @(posedge clk);
        #1;
        q.push_back(predict());
    endtask

    task automatic stall(int n, logic [3:0] vv, logic [3:0] rr);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, vv, rr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        model_clear();
        #1;
        q.push_back(predict());
        ->kick;
        #1;
        rst = 1'b0;
    endtask

    task automatic do_clear();
        step(1'b1, 1'b1, 4'b0, 4'b0);
    endtask

    initial begin
        int rp;
        logic [3:0] rr;
        do_reset();

        // single-channel timeout and first-id
        stall(10, 4'b0010, 4'b0000);
        do_clear();

        // handshake one cycle before the limit
        stall(7, 4'b0001, 4'b0000);
        stall(1, 4'b0001, 4'b0001);
        stall(3, 4'b0000, 4'b0000);
        do_clear();

        // simultaneous timeouts, then a later one
        stall(9, 4'b1100, 4'b0000);
        stall(9, 4'b0001, 4'b0000);
        do_clear();

        // deadlock, then near-miss with a handshake on cycle 15
        stall(17, 4'b1111, 4'b0000);
        do_clear();
        stall(14, 4'b1111, 4'b0000);
        stall(1, 4'b1111, 4'b0001);
        stall(14, 4'b1111, 4'b0000);
        do_clear();

        // clear coinciding with timeout entry
        stall(7, 4'b0001, 4'b0000);
        step(1'b1, 1'b1, 4'b0001, 4'b0000);
        stall(3, 4'b0001, 4'b0000);
        do_clear();

        // async reset mid-wait, then a fresh stall
        stall(4, 4'b0001, 4'b0000);
        do_reset();
        stall(9, 4'b0001, 4'b0000);
        do_clear();

        // enable low freezes everything
        stall(5, 4'b0100, 4'b0000);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 4'b0100, 4'b0000);
        stall(4, 4'b0100, 4'b0000);
        do_clear();

        // randomized blocks with varying ready density
        for (int b = 0; b < 15; b++) begin
            case ($urandom_range(0, 2))
                0: rp = 2;
                1: rp = 10;
                default: rp = 50;
            endcase
            for (int i = 0; i < 40; i++) begin
                for (int c = 0; c < N; c++) rr[c] = ($urandom_range(0, 99) < rp);
                if ($urandom_range(0, 199) == 0) do_reset();
                step($urandom_range(0, 15) != 0, $urandom_range(0, 63) == 0,
                     4'($urandom), rr);
            end
        end

        @(negedge clk);
        #1;
        vectors++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/bsg_gateway_progress_watchdog.md
BSG_GATEWAY_PROGRESS_WATCHDOG -- requirements
Module: bsg_gateway_progress_watchdog

Interface
REQ-001 SHALL have parameter num_channels_p, default 4, the number of monitored valid/ready channels (1..16).
REQ-002 SHALL have parameter stall_limit_p, default 1024, the number of consecutive stalled cycles that declares a channel timeout (>=2).
REQ-003 SHALL have parameter idle_limit_p, default 500000, the number of consecutive cycles without any handshake that declares a global deadlock (>=2).
REQ-004 SHALL have port clk_i, input, 1, the single clock.
REQ-005 SHALL have port reset_i, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port en_i, input, 1; when low, all counters and states hold.
REQ-007 SHALL have port clear_i, input, 1, synchronous clear of all counters, states and sticky outputs.
REQ-008 SHALL have port v_i, input, num_channels_p, per-channel valid.
REQ-009 SHALL have port ready_and_i, input, num_channels_p, per-channel ready; a handshake is v_i[c] & ready_and_i[c].
REQ-010 SHALL have port timeout_o, output, num_channels_p, sticky per-channel timeout flags.
REQ-011 SHALL have port first_id_o, output, clog2(num_channels_p) (safe), the index of the first channel to time out.
REQ-012 SHALL have port first_v_o, output, 1, which qualifies first_id_o.
REQ-013 SHALL have port deadlock_o, output, 1, sticky global no-progress flag.

Function
REQ-014 Each channel SHALL run a FSM with states IDLE, WAIT and TIMEOUT, plus a saturating stall counter of width clog2(stall_limit_p+1).
REQ-015 In IDLE, v_i=1 & ready_and_i=0 SHALL move the channel to WAIT with count=1; a same-cycle handshake SHALL stay in IDLE.
REQ-016 In WAIT, a handshake or v_i=0 SHALL return the channel to IDLE with count=0; a continued stall SHALL increment the count.
REQ-017 In WAIT, a stall when count==stall_limit_p-1 SHALL move the channel to TIMEOUT. timeout_o[c] SHALL then read 1 from the next cycle, i.e. exactly stall_limit_p consecutive stalled cycles after the stall began.
REQ-018 TIMEOUT SHALL be absorbing: a later handshake SHALL NOT clear it; only clear_i or reset_i clears it.
REQ-019 The global idle counter SHALL count cycles with en_i=1, at least one v_i bit set, and no handshake on any channel.
REQ-020 The global idle counter SHALL reset to 0 on any handshake, and SHALL hold when all v_i bits are 0.
REQ-021 deadlock_o SHALL rise after idle_limit_p consecutive counted cycles and SHALL be sticky.
REQ-022 first_id_o/first_v_o SHALL latch on the first cycle any channel enters TIMEOUT, choosing the lowest index among simultaneous entries. Later timeouts SHALL NOT change them.
REQ-023 clear_i SHALL take priority over a same-cycle timeout or deadlock entry: that entry is discarded.
REQ-024 With en_i=0, no state, counter or sticky output SHALL change, except under clear_i or reset_i.
REQ-025 Counters SHALL saturate and never wrap.

Reset
REQ-026 reset_i SHALL asynchronously force all channels to IDLE, all counters to 0, and timeout_o=0, first_v_o=0, first_id_o=0, deadlock_o=0.
REQ-027 A reset asserted mid-stall SHALL discard the partial count; counting restarts from 0 after deassertion.

Configuration
REQ-028 With macro BSG_GATEWAY_WATCHDOG_FINISH_EN defined, the first rising of first_v_o or deadlock_o SHALL $display the channel id or "DEADLOCK" plus the cycle count, then call $finish at the next negedge.
REQ-029 Without BSG_GATEWAY_WATCHDOG_FINISH_EN, no simulation-control code SHALL be compiled and the block SHALL be synthesizable.

Structure
REQ-030 The channel state enum (e_wd_idle, e_wd_wait, e_wd_timeout) SHALL reside in package bsg_gateway_watchdog_pkg.
REQ-031 Per-channel FSM and counter SHALL be sub-module bsg_gateway_watchdog_channel, instantiated num_channels_p times.
REQ-032 The global idle counter, first-id priority latch and finish logic SHALL reside in the top module.

Verification (num_channels_p=4, stall_limit_p=8, idle_limit_p=16)
REQ-033 Hold v_i=4'b0010, ready_and_i=0 for 8 cycles -> timeout_o=4'b0010 on cycle 9, first_id_o=1, first_v_o=1.
REQ-034 Hold v_i[0]=1, ready_and_i[0]=0 for 7 cycles, then assert ready_and_i[0] for 1 cycle -> count returns to 0, timeout_o stays 0.
REQ-035 Stall channels 2 and 3 starting the same cycle -> timeout_o=4'b1100 and first_id_o=2; a later channel-0 timeout leaves first_id_o=2.
REQ-036 Hold v_i=4'b1111, ready_and_i=0 with stall_limit_p raised to 64 -> deadlock_o=1 after 16 cycles; a handshake on cycle 15 resets the count and no deadlock occurs.
REQ-037 Pulse clear_i on the same cycle channel 0 would enter TIMEOUT -> timeout_o stays 0 and first_v_o stays 0.
REQ-038 Assert reset_i asynchronously mid-WAIT, then stall 8 cycles -> timeout_o[c]=1 exactly 8 cycles after the stall began, not earlier.
